control_unit: RTL
=================

// Module: control_unit
// PURPOSE
//  Instruction sequencer for the 8-bit processor core.
//  Consumes the opcode fetched by the datapath and drives the datapath control inputs:
//   pc_load, reg_load_a, reg_load_b, reg_load_c, ram_we.
//  Moore FSM, one instruction at a time. Also gates program loading into RAM while idle.
// PARAMETERS
//  NOP_OP      8'h00  opcode of no-operation (1 byte)
//  ALU_OP_MIN  8'h01  lowest ALU opcode (3 bytes: opcode, operand1, operand2)
//  ALU_OP_MAX  8'h0F  highest ALU opcode
//  HLT_OP      8'hFF  opcode that stops the sequencer
//  ALU_LAT     1      clock cycles from A/B load to valid ALU output (range 1..7)
//  COUNT_W     16     width of retired-instruction counter
// PORTS
//  clock        in   1        system clock, rising edge
//  reset        in   1        asynchronous, active-high; returns FSM to IDLE
//  start        in   1        level/pulse; begins execution when in IDLE
//  prog_we      in   1        external program-load write strobe
//  opcode       in   8        opcode at current PC (datapath RAM read port)
//  pc_load      out  1        one-cycle pulse: PC advances per opcode length
//  reg_load_a   out  1        load register A from operand1
//  reg_load_b   out  1        load register B from operand2
//  reg_load_c   out  1        write ALU result into register C
//  ram_we       out  1        RAM write enable
//  busy         out  1        high in every state except IDLE and HALT
//  halted       out  1        high in HALT
//  illegal_op   out  1        sticky; set when an undefined opcode is decoded
//  instr_count  out  COUNT_W  retired instructions, saturates at all-ones
// BEHAVIOUR
//  - Reset: state=IDLE; all outputs 0; ir=0; lat counter=0; instr_count=0.
//    Reset mid-instruction aborts it, with no pc_load/reg_load pulse on the reset edge.
//  - All outputs are registered or state-decoded; no combinational path from opcode to outputs.
//    Exception: ram_we = prog_we while state==IDLE, else 0.
//  - States and transitions:
//    - IDLE: start & !prog_we -> FETCH. prog_we has priority over start.
//    - FETCH: 1 cycle; lets the RAM read settle -> DECODE.
//    - DECODE: ir<=opcode.
//      - NOP_OP -> NEXT.
//      - ALU_OP_MIN..ALU_OP_MAX -> LOAD.
//      - HLT_OP -> HALT.
//      - Other opcodes: illegal_op<=1 -> HALT.
//    - LOAD: reg_load_a=reg_load_b=1 for exactly 1 cycle -> EXEC; lat counter<=0.
//    - EXEC: count to ALU_LAT-1, then -> WB. Dwell is exactly ALU_LAT cycles.
//    - WB: reg_load_c=1 for 1 cycle -> NEXT.
//    - NEXT: pc_load=1 for 1 cycle; instr_count+=1 (saturating) -> FETCH.
//    - HALT: halted=1; start ignored; only reset leaves HALT. HLT is not counted.
//  - start is ignored outside IDLE; prog_we is ignored outside IDLE.
//  - ALU instruction latency is FETCH+DECODE+LOAD+EXEC(ALU_LAT)+WB+NEXT = 5+ALU_LAT cycles.
//    NOP latency is 3 cycles.
//  - At most one of reg_load_a/b, reg_load_c, pc_load is active in any cycle.
//  - opcode is only sampled in DECODE; changes at other times have no effect.
// TESTING
//  1. Assert reset mid-EXEC -> all outputs 0 on the same cycle.
//     Then start -> FETCH; instr_count=0.
//  2. RAM holds {8'h01,x,y,8'hFF}, ALU_LAT=1, start at cycle 0.
//     -> reg_load_a/b at cycle 3, reg_load_c at cycle 5, pc_load at cycle 6.
//     -> halted at cycle 9; instr_count=1.
//  3. Opcode 8'h00 three times, then 8'hFF.
//     -> pc_load pulses at cycles 3, 6, 9; no reg_load_*; instr_count=3; halted=1.
//  4. Opcode 8'h42 -> illegal_op=1 and halted=1 after DECODE; pc_load never pulses.
//  5. In IDLE, prog_we=1 and start=1 together -> ram_we=1 and state stays IDLE.
//     Release prog_we -> FETCH on next edge.
//  6. ALU_LAT=3 -> exactly 3 EXEC cycles between reg_load_a and reg_load_c.
//     Preload instr_count to all-ones -> it holds at all-ones.

Source files
------------

// File: rtl/control_unit.sv
// Instruction sequencer for the 8-bit core.
// Moore FSM that walks one instruction at a time through
// FETCH/DECODE/LOAD/EXEC/WB/NEXT and drives the datapath load strobes.
// While idle it forwards the external program-load strobe to the RAM.
module control_unit #(
  parameter logic [7:0] NOP_OP     = 8'h00,
  parameter logic [7:0] ALU_OP_MIN = 8'h01,
  parameter logic [7:0] ALU_OP_MAX = 8'h0F,
  parameter logic [7:0] HLT_OP     = 8'hFF,
  parameter int         ALU_LAT    = 1,
  parameter int         COUNT_W    = 16
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               start,
  input  logic               prog_we,
  input  logic [7:0]         opcode,
  output logic               pc_load,
  output logic               reg_load_a,
  output logic               reg_load_b,
  output logic               reg_load_c,
  output logic               ram_we,
  output logic               busy,
  output logic               halted,
  output logic               illegal_op,
  output logic [COUNT_W-1:0] instr_count
);

  // The EXEC dwell counter only ever needs to reach ALU_LAT-1 (at most 6).
  localparam logic [2:0] LAT_LAST = 3'(ALU_LAT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_LOAD,
    S_EXEC,
    S_WB,
    S_NEXT,
    S_HALT
  } state_t;

  state_t               state_q, state_d;
  logic [7:0]           ir_q, ir_d;
  logic [2:0]           lat_q, lat_d;
  logic                 illegal_q, illegal_d;
  logic [COUNT_W-1:0]   count_q, count_d;
  logic                 ir_is_alu;

  // Saturating increment of the retired-instruction counter.
  function automatic logic [COUNT_W-1:0] sat_inc(input logic [COUNT_W-1:0] v);
    if (&v) sat_inc = v;
    else    sat_inc = v + 1'b1;
  endfunction

  // The latched instruction gates the operand loads, so a stale opcode on the
  // RAM port outside DECODE can never produce a register load.
  assign ir_is_alu = (ir_q >= ALU_OP_MIN) && (ir_q <= ALU_OP_MAX);

  // State, instruction register, dwell counter and status flops.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      ir_q      <= 8'h00;
      lat_q     <= 3'd0;
      illegal_q <= 1'b0;
      count_q   <= '0;
    end else begin
      state_q   <= state_d;
      ir_q      <= ir_d;
      lat_q     <= lat_d;
      illegal_q <= illegal_d;
      count_q   <= count_d;
    end
  end

  // Next-state logic; opcode is consulted only in DECODE.
  always_comb begin
    state_d   = state_q;
    ir_d      = ir_q;
    lat_d     = lat_q;
    illegal_d = illegal_q;
    count_d   = count_q;
    case (state_q)
      S_IDLE: begin
        // A program write in progress wins over start.
        if (start && !prog_we) state_d = S_FETCH;
      end
      S_FETCH: begin
        state_d = S_DECODE;
      end
      S_DECODE: begin
        ir_d = opcode;
        if (opcode == NOP_OP) begin
          state_d = S_NEXT;
        end else if ((opcode >= ALU_OP_MIN) && (opcode <= ALU_OP_MAX)) begin
          state_d = S_LOAD;
        end else if (opcode == HLT_OP) begin
          state_d = S_HALT;
        end else begin
          illegal_d = 1'b1;
          state_d   = S_HALT;
        end
      end
      S_LOAD: begin
        lat_d   = 3'd0;
        state_d = S_EXEC;
      end
      S_EXEC: begin
        if (lat_q == LAT_LAST) state_d = S_WB;
        else                   lat_d   = lat_q + 3'd1;
      end
      S_WB: begin
        state_d = S_NEXT;
      end
      S_NEXT: begin
        count_d = sat_inc(count_q);
        state_d = S_FETCH;
      end
      S_HALT: begin
        state_d = S_HALT;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Outputs decoded from the registered state only; ram_we is the one
  // deliberate pass-through, and only while idle.
  always_comb begin
    pc_load     = (state_q == S_NEXT);
    reg_load_a  = (state_q == S_LOAD) && ir_is_alu;
    reg_load_b  = (state_q == S_LOAD) && ir_is_alu;
    reg_load_c  = (state_q == S_WB);
    ram_we      = (state_q == S_IDLE) && prog_we;
    busy        = (state_q != S_IDLE) && (state_q != S_HALT);
    halted      = (state_q == S_HALT);
    illegal_op  = illegal_q;
    instr_count = count_q;
  end

endmodule
